// File: rtl/vsddeserializer_v1.sv
// Serial-to-parallel word receiver: FRAME marks each word's MSB, bits arrive MSB first.
// Registered word output with single-cycle VALID/ERR pulses and a BUSY status flag.
module vsddeserializer_v1 #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             FRAME,
  input  logic             SIN,
  output logic [WIDTH-1:0] OUTPUT,
  output logic             VALID,
  output logic             ERR,
  output logic             BUSY
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] out_next;
  logic             valid_next;
  logic             err_next;
  logic [WIDTH-1:0] shifted;

  assign shifted = {sr[WIDTH-2:0], SIN};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (FRAME) state_next = SHIFT;
      end
      SHIFT: begin
        if (!FRAME && (cnt == LAST)) state_next = IDLE;
      end
    endcase
  end

  // Datapath and output next values; a FRAME inside a word restarts it with an ERR pulse
  always_comb begin
    cnt_next   = cnt;
    sr_next    = sr;
    out_next   = OUTPUT;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (FRAME) begin
          sr_next  = WIDTH'(SIN);
          cnt_next = CW'(1);
        end
      end
      SHIFT: begin
        if (FRAME) begin
          err_next = 1'b1;
          sr_next  = WIDTH'(SIN);
          cnt_next = CW'(1);
        end else if (cnt == LAST) begin
          out_next   = shifted;
          valid_next = 1'b1;
          cnt_next   = '0;
        end else begin
          sr_next  = shifted;
          cnt_next = cnt + CW'(1);
        end
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sr     <= '0;
      OUTPUT <= '0;
      VALID  <= 1'b0;
      ERR    <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      sr     <= sr_next;
      OUTPUT <= out_next;
      VALID  <= valid_next;
      ERR    <= err_next;
      BUSY   <= (state_next == SHIFT);
    end
  end

endmodule

// File: tb/tb_vsddeserializer_v1.sv
// Randomized self-checking bench for vsddeserializer_v1 against a queue-based word model.
module tb_vsddeserializer_v1;

  localparam int unsigned W = 10;

  logic         clk;
  logic         rst_n;
  logic         FRAME;
  logic         SIN;
  logic [W-1:0] OUTPUT;
  logic         VALID;
  logic         ERR;
  logic         BUSY;

  int n_vec;
  int n_bad;
  int cyc_no;

  // Reference model: bits collected since the last FRAME, plus expected outputs
  logic         collecting;
  logic         bits_q[$];
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_err;

  vsddeserializer_v1 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .FRAME  (FRAME),
    .SIN    (SIN),
    .OUTPUT (OUTPUT),
    .VALID  (VALID),
    .ERR    (ERR),
    .BUSY   (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    collecting = 1'b0;
    bits_q     = {};
    m_out      = '0;
    m_valid    = 1'b0;
    m_err      = 1'b0;
  endtask

  // Apply one bit-cycle, advance the model over the clock edge, settle 1 time unit later
  task automatic cyc(input logic f, input logic s);
    logic [W-1:0] word;
    FRAME = f;
    SIN   = s;
    @(posedge clk);
    cyc_no++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (f) begin
      if (collecting) m_err = 1'b1;
      bits_q     = {s};
      collecting = 1'b1;
    end else if (collecting) begin
      bits_q.push_back(s);
      if (bits_q.size() == W) begin
        word = '0;
        foreach (bits_q[i]) word = {word[W-2:0], bits_q[i]};
        m_out      = word;
        m_valid    = 1'b1;
        collecting = 1'b0;
        bits_q     = {};
      end
    end
    #1;
  endtask

  function automatic logic msb_bit(input logic [W-1:0] w, input int i);
    return w[W-1-i];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    FRAME = 1'b1;
    SIN   = 1'b1;
    model_reset();
    #2;
    n_vec++;
    if ({OUTPUT, VALID, ERR, BUSY} !== {W'(0), 3'b000}) begin
      n_bad++;
      $display("FAIL reset_async: got out=%h v=%b e=%b b=%b, want all 0", OUTPUT, VALID, ERR, BUSY);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      SIN = ~SIN;
      n_vec++;
      if ({OUTPUT, VALID, ERR, BUSY} !== {W'(0), 3'b000}) begin
        n_bad++;
        $display("FAIL reset_held: got out=%h v=%b e=%b b=%b, want all 0", OUTPUT, VALID, ERR, BUSY);
      end
    end
    FRAME = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    int vcount;
    vcount = 0;
    for (int i = 0; i < int'(W); i++) begin
      cyc(i == 0, msb_bit(10'h2B5, i));
      if (VALID) vcount++;
      n_vec++;
      if ({OUTPUT, VALID, ERR, BUSY} !== {m_out, m_valid, m_err, collecting}) begin
        n_bad++;
        $display("FAIL single bit%0d: got out=%h v=%b e=%b b=%b want out=%h v=%b e=%b b=%b",
                 i, OUTPUT, VALID, ERR, BUSY, m_out, m_valid, m_err, collecting);
      end
    end
    n_vec++;
    if (OUTPUT !== 10'h2B5 || VALID !== 1'b1 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after_lsb: got out=%h v=%b b=%b want out=2b5 v=1 b=0", OUTPUT, VALID, BUSY);
    end
    cyc(1'b0, 1'b1);
    n_vec++;
    if (VALID !== 1'b0 || vcount != 1 || OUTPUT !== 10'h2B5) begin
      n_bad++;
      $display("FAIL single_pulse: got v=%b count=%0d out=%h want v=0 count=1 out=2b5", VALID, vcount, OUTPUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    logic [W-1:0] got   [$];
    int           when  [$];
    words = '{10'h3FF, 10'h000, 10'h155};
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < int'(W); i++) begin
        cyc(i == 0, msb_bit(words[w], i));
        if (VALID) begin
          got.push_back(OUTPUT);
          when.push_back(cyc_no);
        end
        n_vec++;
        if ({OUTPUT, VALID, ERR, BUSY} !== {m_out, m_valid, m_err, collecting}) begin
          n_bad++;
          $display("FAIL b2b w%0d bit%0d: got out=%h v=%b e=%b b=%b want out=%h v=%b e=%b b=%b",
                   w, i, OUTPUT, VALID, ERR, BUSY, m_out, m_valid, m_err, collecting);
        end
      end
    end
    cyc(1'b0, 1'b0);
    n_vec++;
    if (got.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d VALID pulses want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got[k] !== words[k]) begin
          n_bad++;
          $display("FAIL b2b_word%0d: got %h want %h", k, got[k], words[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_vec++;
        if (when[k] - when[k-1] != int'(W)) begin
          n_bad++;
          $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", k, when[k] - when[k-1], W);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] prev;
    prev = m_out;
    for (int i = 0; i < 5; i++) cyc(i == 0, msb_bit(10'h2B5, i));
    for (int i = 0; i < int'(W); i++) begin
      cyc(i == 0, msb_bit(10'h0F0, i));
      n_vec++;
      if ({OUTPUT, VALID, ERR, BUSY} !== {m_out, m_valid, m_err, collecting}) begin
        n_bad++;
        $display("FAIL abort bit%0d: got out=%h v=%b e=%b b=%b want out=%h v=%b e=%b b=%b",
                 i, OUTPUT, VALID, ERR, BUSY, m_out, m_valid, m_err, collecting);
      end
      if (i == 0) begin
        n_vec++;
        if (ERR !== 1'b1 || VALID !== 1'b0 || OUTPUT !== prev) begin
          n_bad++;
          $display("FAIL abort_err: got e=%b v=%b out=%h want e=1 v=0 out=%h", ERR, VALID, OUTPUT, prev);
        end
      end
    end
    n_vec++;
    if (VALID !== 1'b1 || OUTPUT !== 10'h0F0 || ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_recover: got v=%b e=%b out=%h want v=1 e=0 out=0f0", VALID, ERR, OUTPUT);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_late_abort();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] prev;
    a    = W'($urandom);
    b    = W'($urandom);
    prev = m_out;
    for (int i = 0; i < int'(W) - 1; i++) cyc(i == 0, msb_bit(a, i));
    for (int i = 0; i < int'(W); i++) begin
      cyc(i == 0, msb_bit(b, i));
      if (i == 0) begin
        n_vec++;
        if (ERR !== 1'b1 || VALID !== 1'b0 || BUSY !== 1'b1 || OUTPUT !== prev) begin
          n_bad++;
          $display("FAIL late_abort: got e=%b v=%b b=%b out=%h want e=1 v=0 b=1 out=%h",
                   ERR, VALID, BUSY, OUTPUT, prev);
        end
      end
    end
    n_vec++;
    if (VALID !== 1'b1 || OUTPUT !== b) begin
      n_bad++;
      $display("FAIL late_abort_next: got v=%b out=%h want v=1 out=%h", VALID, OUTPUT, b);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 6; i++) cyc(i == 0, msb_bit(10'h2B5, i));
    FRAME = 1'b0;
    SIN   = msb_bit(10'h2B5, 6);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({OUTPUT, VALID, ERR, BUSY} !== {W'(0), 3'b000}) begin
      n_bad++;
      $display("FAIL midreset_async: got out=%h v=%b e=%b b=%b want all 0", OUTPUT, VALID, ERR, BUSY);
    end
    FRAME = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({OUTPUT, VALID, ERR, BUSY} !== {W'(0), 3'b000}) begin
      n_bad++;
      $display("FAIL midreset_held: got out=%h v=%b e=%b b=%b want all 0", OUTPUT, VALID, ERR, BUSY);
    end
    FRAME = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      cyc(i == 0, msb_bit(10'h1A5, i));
      n_vec++;
      if ({OUTPUT, VALID, ERR, BUSY} !== {m_out, m_valid, m_err, collecting}) begin
        n_bad++;
        $display("FAIL midreset_word bit%0d: got out=%h v=%b e=%b b=%b want out=%h v=%b e=%b b=%b",
                 i, OUTPUT, VALID, ERR, BUSY, m_out, m_valid, m_err, collecting);
      end
    end
    n_vec++;
    if (OUTPUT !== 10'h1A5 || VALID !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_result: got out=%h v=%b want out=1a5 v=1", OUTPUT, VALID);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_idle_noise();
    logic [W-1:0] held;
    held = m_out;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'($urandom));
      n_vec++;
      if ({OUTPUT, VALID, ERR, BUSY} !== {held, 3'b000}) begin
        n_bad++;
        $display("FAIL idle_noise cyc%0d: got out=%h v=%b e=%b b=%b want out=%h v=0 e=0 b=0",
                 i, OUTPUT, VALID, ERR, BUSY, held);
      end
    end
  endtask

  task automatic test_random_traffic();
    logic f;
    for (int i = 0; i < 600; i++) begin
      if (!collecting) f = ($urandom_range(0, 2) == 0);
      else f = ($urandom_range(0, 14) == 0);
      cyc(f, 1'($urandom));
      n_vec++;
      if ({OUTPUT, VALID, ERR, BUSY} !== {m_out, m_valid, m_err, collecting}) begin
        n_bad++;
        $display("FAIL random cyc%0d: got out=%h v=%b e=%b b=%b want out=%h v=%b e=%b b=%b",
                 i, OUTPUT, VALID, ERR, BUSY, m_out, m_valid, m_err, collecting);
      end
      n_vec++;
      if (VALID && ERR) begin
        n_bad++;
        $display("FAIL random_exclusive cyc%0d: got v=%b e=%b want not both", i, VALID, ERR);
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    cyc_no = 0;
    FRAME  = 1'b0;
    SIN    = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    #3;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_late_abort();
    test_reset_mid_word();
    test_idle_noise();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
